// File: rtl/arith_pkg.sv
// arith_pkg
// Shared definitions for the sequential arithmetic units (multiply-add and
// the pipelined divider).
//   state_t       : control states of the iterative multiply-add unit
//   REP_SIGNED /
//   REP_UNSIGNED  : operand representation names used as parameter values
//   abs_mag()     : magnitude and sign of a two's complement or unsigned value
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    FIX,
    DONE
  } state_t;

  localparam string REP_SIGNED   = "SIGNED";
  localparam string REP_UNSIGNED = "UNSIGNED";

  // value holds a width-bit operand zero-extended to 64 bits (width <= 64).
  // The returned magnitude is meaningful in its low width bits; the caller
  // truncates. The most-negative value maps to 2^(width-1), which still fits
  // as an unsigned width-bit number.
  function automatic logic [63:0] abs_mag(input logic [63:0] value,
                                          input int unsigned width,
                                          input logic is_signed,
                                          output logic sign);
    sign = is_signed && value[6'(width - 1)];
    return sign ? (~value + 64'd1) : value;
  endfunction

endpackage

// File: rtl/seq_mult_add_if.sv
// seq_mult_add_if
// Operand/result handshake bundle of the multiply-add unit.
//   in_valid/in_ready   : operand handshake (a, b, addend)
//   out_valid/out_ready : result handshake (result)
// master = producer/consumer side, slave = the arithmetic unit.
interface seq_mult_add_if #(
  parameter int WIDTHA = 16,
  parameter int WIDTHB = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTHA-1:0]        a;
  logic [WIDTHB-1:0]        b;
  logic [WIDTHA+WIDTHB-1:0] addend;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTHA+WIDTHB-1:0] result;

  modport master (
    output in_valid, a, b, addend, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, a, b, addend, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/seq_mult_add_datapath.sv
// seq_mult_add_datapath
// Shift-and-add datapath of the multiply-add unit.
//   clock, reset : clock and synchronous active-high reset
//   load         : capture magnitudes, sign and addend; clear accumulator
//   step         : one radix-2 iteration
//   fix          : apply sign and add the addend into result
//   mag_a, mag_b : operand magnitudes
//   sign, addend : product sign and addend captured on load
//   last         : current step is the final iteration
//   result       : registered final value
module seq_mult_add_datapath #(
  parameter int WIDTHA = 16,
  parameter int WIDTHB = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     load,
  input  logic                     step,
  input  logic                     fix,
  input  logic [WIDTHA-1:0]        mag_a,
  input  logic [WIDTHB-1:0]        mag_b,
  input  logic                     sign,
  input  logic [WIDTHA+WIDTHB-1:0] addend,
  output logic                     last,
  output logic [WIDTHA+WIDTHB-1:0] result
);
  localparam int W  = WIDTHA + WIDTHB;
  localparam int CW = $clog2(WIDTHB + 1);

  logic [WIDTHA-1:0] a_reg;
  logic [WIDTHB-1:0] b_reg;
  logic [W-1:0]      acc_reg;
  logic [W-1:0]      addend_reg;
  logic [CW-1:0]     count_reg;
  logic              sign_reg;
  logic [W-1:0]      result_reg;

  assign last   = (count_reg == CW'(WIDTHB - 1));
  assign result = result_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      addend_reg <= '0;
      count_reg  <= '0;
      sign_reg   <= 1'b0;
      result_reg <= '0;
    end else begin
      if (load) begin
        a_reg      <= mag_a;
        b_reg      <= mag_b;
        sign_reg   <= sign;
        addend_reg <= addend;
        acc_reg    <= '0;
        count_reg  <= '0;
      end else if (step) begin
        // The product bits never exceed W, so the shifted partial fits.
        if (b_reg[0]) begin
          acc_reg <= acc_reg + (W'(a_reg) << count_reg);
        end
        b_reg     <= b_reg >> 1;
        count_reg <= count_reg + CW'(1);
      end
      if (fix) begin
        result_reg <= (sign_reg ? (~acc_reg + W'(1)) : acc_reg) + addend_reg;
      end
    end
  end
endmodule

// File: rtl/seq_mult_add.sv
// seq_mult_add
// Iterative radix-2 multiply-add: result = (a*b + addend) mod 2^(WIDTHA+WIDTHB).
// Operands may independently be signed (two's complement) or unsigned.
//   clock : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : slave side of seq_mult_add_if (operand and result handshakes)
// One operation in flight; output valid WIDTHB+1 edges after the accept edge.
module seq_mult_add
  import arith_pkg::*;
#(
  parameter int    WIDTHA          = 16,
  parameter int    WIDTHB          = 16,
  parameter string AREPRESENTATION = "UNSIGNED",
  parameter string BREPRESENTATION = "UNSIGNED"
) (
  input logic          clock,
  input logic          reset,
  seq_mult_add_if.slave bus
);
  localparam bit A_SIGNED = (AREPRESENTATION == REP_SIGNED);
  localparam bit B_SIGNED = (BREPRESENTATION == REP_SIGNED);

  state_t            state;
  logic              out_valid_reg;
  logic [WIDTHA-1:0] mag_a;
  logic [WIDTHB-1:0] mag_b;
  logic              sign_a;
  logic              sign_b;
  logic              accept;
  logic              last;

  always_comb begin
    sign_a = 1'b0;
    sign_b = 1'b0;
    mag_a  = WIDTHA'(abs_mag(64'(bus.a), WIDTHA, A_SIGNED, sign_a));
    mag_b  = WIDTHB'(abs_mag(64'(bus.b), WIDTHB, B_SIGNED, sign_b));
  end

  assign accept        = bus.in_valid && (state == IDLE);
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      out_valid_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) state <= MUL;
        MUL:  if (last) state <= FIX;
        FIX: begin
          state         <= DONE;
          out_valid_reg <= 1'b1;
        end
        DONE: begin
          // Returning to IDLE first keeps in->out free of combinational paths.
          if (bus.out_ready) begin
            state         <= IDLE;
            out_valid_reg <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  seq_mult_add_datapath #(
    .WIDTHA(WIDTHA),
    .WIDTHB(WIDTHB)
  ) u_datapath (
    .clock (clock),
    .reset (reset),
    .load  (accept),
    .step  (state == MUL),
    .fix   (state == FIX),
    .mag_a (mag_a),
    .mag_b (mag_b),
    .sign  (sign_a ^ sign_b),
    .addend(bus.addend),
    .last  (last),
    .result(bus.result)
  );
endmodule

// File: tb/tb_seq_mult_add.sv
// tb_seq_mult_add
// Drives three 8x8 instances (unsigned/unsigned, signed/signed,
// unsigned a / signed b) in lockstep with identical stimulus and compares
// each against hand-computed vectors and an integer reference model.
module tb_seq_mult_add;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  seq_mult_add_if #(.WIDTHA(8), .WIDTHB(8)) u_if ();
  seq_mult_add_if #(.WIDTHA(8), .WIDTHB(8)) s_if ();
  seq_mult_add_if #(.WIDTHA(8), .WIDTHB(8)) m_if ();

  seq_mult_add #(.WIDTHA(8), .WIDTHB(8), .AREPRESENTATION("UNSIGNED"), .BREPRESENTATION("UNSIGNED"))
    dut_uu (.clock(clock), .reset(reset), .bus(u_if));
  seq_mult_add #(.WIDTHA(8), .WIDTHB(8), .AREPRESENTATION("SIGNED"), .BREPRESENTATION("SIGNED"))
    dut_ss (.clock(clock), .reset(reset), .bus(s_if));
  seq_mult_add #(.WIDTHA(8), .WIDTHB(8), .AREPRESENTATION("UNSIGNED"), .BREPRESENTATION("SIGNED"))
    dut_us (.clock(clock), .reset(reset), .bus(m_if));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] add;
    logic [15:0] e_uu;
    logic [15:0] e_ss;
    logic [15:0] e_us;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the interpreted operand values.
  function automatic logic [15:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                        input logic [15:0] madd, input bit sa, input bit sb);
    longint av, bv, addv;
    av   = sa ? longint'($signed(ma)) : longint'(ma);
    bv   = sb ? longint'($signed(mb)) : longint'(mb);
    addv = longint'(madd);
    return 16'((av * bv + addv) % 65536);
  endfunction

  task automatic drive(input logic v, input logic [7:0] da, input logic [7:0] db, input logic [15:0] dadd);
    u_if.in_valid = v; u_if.a = da; u_if.b = db; u_if.addend = dadd;
    s_if.in_valid = v; s_if.a = da; s_if.b = db; s_if.addend = dadd;
    m_if.in_valid = v; m_if.a = da; m_if.b = db; m_if.addend = dadd;
  endtask

  task automatic set_out_ready(input logic r);
    u_if.out_ready = r;
    s_if.out_ready = r;
    m_if.out_ready = r;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (!u_if.in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("idle_before_op", {31'd0, u_if.in_ready}, 32'd1);
  endtask

  // Issue one operation, wait for the result, optionally hold it under
  // backpressure for 'hold' cycles while junk operands are offered, release.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_, input logic [15:0] tadd,
                       input int hold, output logic [15:0] ru, output logic [15:0] rs,
                       output logic [15:0] rm);
    int lat;
    bit busy_ok;
    wait_idle();
    drive(1'b1, ta, tb_, tadd);
    tick();
    // Operands are only required on the accept edge; offer junk afterwards.
    drive(1'b1, ~ta, tb_ + 8'd3, ~tadd);
    lat = 0;
    busy_ok = 1'b1;
    while (!u_if.out_valid && lat < 40) begin
      if (u_if.in_ready || s_if.in_ready || m_if.in_ready) busy_ok = 1'b0;
      tick();
      lat++;
    end
    check("in_ready_low_while_busy", {31'd0, busy_ok}, 32'd1);
    check("latency", lat, 32'd9);
    check("out_valid_all", {29'd0, u_if.out_valid, s_if.out_valid, m_if.out_valid}, 32'd7);
    check("in_ready_low_in_done", {31'd0, u_if.in_ready}, 32'd0);
    ru = u_if.result;
    rs = s_if.result;
    rm = m_if.result;
    for (int h = 0; h < hold; h++) begin
      drive(h[0], 8'(h * 37), 8'(h * 11 + 1), 16'(h * 999));
      tick();
      check("hold_result_uu", {16'd0, u_if.result}, {16'd0, ru});
      check("hold_result_ss", {16'd0, s_if.result}, {16'd0, rs});
      check("hold_result_us", {16'd0, m_if.result}, {16'd0, rm});
      check("hold_out_valid", {31'd0, u_if.out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, u_if.in_ready}, 32'd0);
    end
    // Release while a new operand is offered: it must not be taken this edge.
    drive(1'b1, 8'h5A, 8'hA5, 16'h1111);
    set_out_ready(1'b1);
    tick();
    set_out_ready(1'b0);
    drive(1'b0, 8'h00, 8'h00, 16'h0000);
    check("release_out_valid", {31'd0, u_if.out_valid}, 32'd0);
    check("release_in_ready", {31'd0, u_if.in_ready}, 32'd1);
    tick();
    check("no_accept_on_release", {29'd0, u_if.in_ready, s_if.in_ready, m_if.in_ready}, 32'd7);
    $display("op a=0x%02h b=0x%02h add=0x%04h -> uu=0x%04h ss=0x%04h us=0x%04h lat=%0d hold=%0d",
             ta, tb_, tadd, ru, rs, rm, lat, hold);
  endtask

  initial begin
    logic [15:0] ru, rs, rm;
    logic [7:0]  ra, rb;
    logic [15:0] radd;

    vecs[0] = '{8'hFF, 8'hFF, 16'h0000, 16'hFE01, 16'h0001, 16'hFF01};
    vecs[1] = '{8'h80, 8'h80, 16'h0000, 16'h4000, 16'h4000, 16'hC000};
    vecs[2] = '{8'h80, 8'h7F, 16'h0000, 16'h3F80, 16'hC080, 16'h3F80};
    vecs[3] = '{8'hFD, 8'h05, 16'h0007, 16'h04F8, 16'hFFF8, 16'h04F8};
    vecs[4] = '{8'hC8, 8'hFF, 16'h0000, 16'hC738, 16'h0038, 16'hFF38};
    vecs[5] = '{8'hFF, 8'hFF, 16'hFFFF, 16'hFE00, 16'h0000, 16'hFF00};
    vecs[6] = '{8'h0C, 8'h0A, 16'h0000, 16'h0078, 16'h0078, 16'h0078};
    vecs[7] = '{8'h00, 8'h00, 16'h1234, 16'h1234, 16'h1234, 16'h1234};

    drive(1'b0, 8'h00, 8'h00, 16'h0000);
    set_out_ready(1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("reset_out_valid", {29'd0, u_if.out_valid, s_if.out_valid, m_if.out_valid}, 32'd0);
    check("reset_in_ready", {29'd0, u_if.in_ready, s_if.in_ready, m_if.in_ready}, 32'd7);
    check("reset_result", {16'd0, u_if.result | s_if.result | m_if.result}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].add, 0, ru, rs, rm);
      check($sformatf("vec%0d_uu", i), {16'd0, ru}, {16'd0, vecs[i].e_uu});
      check($sformatf("vec%0d_ss", i), {16'd0, rs}, {16'd0, vecs[i].e_ss});
      check($sformatf("vec%0d_us", i), {16'd0, rm}, {16'd0, vecs[i].e_us});
    end

    // Backpressure: hold the result for 5 cycles while in_valid toggles.
    do_op(8'h07, 8'h09, 16'h0003, 5, ru, rs, rm);
    check("bp_uu", {16'd0, ru}, 32'h0042);
    check("bp_ss", {16'd0, rs}, 32'h0042);
    check("bp_us", {16'd0, rm}, 32'h0042);

    // Reset during MUL step 4 discards the operation and clears result.
    wait_idle();
    drive(1'b1, 8'hF3, 8'h6B, 16'h00FF);
    tick();
    drive(1'b0, 8'h00, 8'h00, 16'h0000);
    for (int k = 0; k < 4; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_out_valid", {29'd0, u_if.out_valid, s_if.out_valid, m_if.out_valid}, 32'd0);
    check("midreset_in_ready", {29'd0, u_if.in_ready, s_if.in_ready, m_if.in_ready}, 32'd7);
    check("midreset_result", {16'd0, u_if.result | s_if.result | m_if.result}, 32'd0);
    $display("reset during MUL step 4 applied");
    do_op(8'd12, 8'd10, 16'h0000, 0, ru, rs, rm);
    check("post_reset_uu", {16'd0, ru}, 32'h0078);
    check("post_reset_ss", {16'd0, rs}, 32'h0078);
    check("post_reset_us", {16'd0, rm}, 32'h0078);

    // Randomised operations against the integer model.
    for (int n = 0; n < 30; n++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      radd = 16'($urandom);
      do_op(ra, rb, radd, int'($urandom_range(0, 2)), ru, rs, rm);
      check("rand_uu", {16'd0, ru}, {16'd0, model(ra, rb, radd, 1'b0, 1'b0)});
      check("rand_ss", {16'd0, rs}, {16'd0, model(ra, rb, radd, 1'b1, 1'b1)});
      check("rand_us", {16'd0, rm}, {16'd0, model(ra, rb, radd, 1'b0, 1'b1)});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
